// File: rtl/apb_cmd_sequencer.sv
// Command front-end for the APB bridge: buffers host read/write commands and walks
// each one through SETUP/ACCESS, returning read data and status with a per-access timeout.
module apb_cmd_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_sel,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        transfer,
  output logic        penable,
  output logic        pwrite,
  output logic [1:0]  Psel,
  output logic [4:0]  write_paddr,
  output logic [4:0]  apb_read_paddr,
  output logic [31:0] write_data,
  input  logic        pready,
  input  logic [31:0] apb_read_data_out,
  input  logic        PSLVERR,
  input  logic [2:0]  Error_Identify,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  rsp_code
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t          fifo_q [CMD_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          empty, full, push, pop;
  cmd_t          head;

  state_t        state_q;
  logic [CW-1:0] tmo_q;
  logic          transfer_q, penable_q, pwrite_q;
  logic [1:0]    psel_q;
  logic [4:0]    waddr_q, raddr_q;
  logic [31:0]   wdata_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [2:0]    rsp_code_q;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = fifo_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge pclk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= '{cmd_write, cmd_sel, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      transfer_q  <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            if (head.sel == 2'd1 || head.sel == 2'd2) begin
              state_q    <= S_SETUP;
              transfer_q <= 1'b1;
              penable_q  <= 1'b0;
              psel_q     <= head.sel;
              pwrite_q   <= head.write;
              waddr_q    <= head.write ? head.addr : 5'd0;
              raddr_q    <= head.write ? 5'd0 : head.addr;
              wdata_q    <= head.wdata;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_code_q  <= 3'b110;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          tmo_q     <= '0;
        end
        S_ACCESS: begin
          // A late pready on the final allowed cycle still wins over the timeout.
          if (pready || tmo_q == CW'(TIMEOUT - 1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= pready ? PSLVERR : 1'b1;
            rsp_code_q  <= pready ? Error_Identify : 3'b111;
            rsp_rdata_q <= (pready && !pwrite_q) ? apb_read_data_out : 32'd0;
            transfer_q  <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            psel_q      <= '0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= '0;
            rsp_rdata_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = !full;
  assign transfer       = transfer_q;
  assign penable        = penable_q;
  assign pwrite         = pwrite_q;
  assign Psel           = psel_q;
  assign write_paddr    = waddr_q;
  assign apb_read_paddr = raddr_q;
  assign write_data     = wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_code       = rsp_code_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Scoreboard bench for apb_cmd_sequencer: directed scenarios followed by random
// commands, a reactive APB slave, and a response monitor checking in command order.
module tb_apb_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        pclk = 1'b0;
  logic        Reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [1:0]  cmd_sel = '0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        transfer, penable, pwrite;
  logic [1:0]  Psel;
  logic [4:0]  write_paddr, apb_read_paddr;
  logic [31:0] write_data;
  logic        pready = 1'b0;
  logic [31:0] apb_read_data_out = '0;
  logic        PSLVERR = 1'b0;
  logic [2:0]  Error_Identify = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_code;

  always #5 pclk = ~pclk;

  apb_cmd_sequencer #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .transfer(transfer), .penable(penable), .pwrite(pwrite), .Psel(Psel),
    .write_paddr(write_paddr), .apb_read_paddr(apb_read_paddr), .write_data(write_data),
    .pready(pready), .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR),
    .Error_Identify(Error_Identify),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_code(rsp_code)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  code;
  } rsp_t;

  // One command plus the slave behaviour chosen for it.
  typedef struct {
    logic        write;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  code;
  } plan_t;

  rsp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    hold_rsp = 1'b0;
  bit    rst_abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic plan_t mk(input bit w, input logic [1:0] s, input logic [4:0] a,
                               input logic [31:0] d, input int waits, input logic [31:0] rd,
                               input bit err, input logic [2:0] code);
    plan_t p;
    p.write = w; p.sel = s; p.addr = a; p.wdata = d;
    p.waits = waits; p.rdata = rd; p.err = err; p.code = code;
    return p;
  endfunction

  function automatic bit legal(input logic [1:0] s);
    return (s == 2'd1) || (s == 2'd2);
  endfunction

  // Reference: what the host should see for this command.
  function automatic rsp_t predict(input plan_t p);
    rsp_t r;
    if (!legal(p.sel))      begin r.rdata = 0; r.err = 1'b1; r.code = 3'b110; end
    else if (p.waits >= TMO) begin r.rdata = 0; r.err = 1'b1; r.code = 3'b111; end
    else begin
      r.rdata = p.write ? 32'd0 : p.rdata;
      r.err   = p.err;
      r.code  = p.code;
    end
    return r;
  endfunction

  task automatic send(input plan_t p);
    bit r, acc;
    acc = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = p.write; cmd_sel = p.sel;
    cmd_addr = p.addr; cmd_wdata = p.wdata;
    for (int i = 0; i < 400; i++) begin
      r = cmd_ready;
      @(posedge pclk);
      if (r) begin acc = 1'b1; break; end
      @(negedge pclk);
    end
    if (acc) begin
      exp_q.push_back(predict(p));
      if (legal(p.sel)) plan_q.push_back(p);
    end else begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge pclk); #2;
      if (exp_q.size() == 0 && !transfer && !rsp_valid) begin done = 1'b1; break; end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // APB slave: consumes one plan entry per SETUP phase and inserts the planned waits.
  initial begin
    plan_t p;
    int    k, n_acc, exp_len;
    bit    hold_ok, in_acc;
    forever begin
      @(posedge pclk); #1;
      if (Reset && transfer && !penable) begin
        if (plan_q.size() == 0) begin
          chk("setup_unplanned", 32'd1, 32'd0);
        end else begin
          p = plan_q.pop_front();
          chk("setup_psel", Psel, p.sel);
          chk("setup_pwrite", pwrite, p.write);
          chk("setup_waddr", write_paddr, p.write ? p.addr : 5'd0);
          chk("setup_raddr", apb_read_paddr, p.write ? 5'd0 : p.addr);
          if (p.write) chk("setup_wdata", write_data, p.wdata);
          apb_read_data_out = p.rdata;
          PSLVERR = p.err;
          Error_Identify = p.code;
          k = 0; n_acc = 0; in_acc = 1'b1;
          while (in_acc) begin
            @(posedge pclk); #1;
            if (!Reset || !penable || n_acc > 3 * TMO) begin
              in_acc = 1'b0;
            end else begin
              hold_ok = transfer && Psel == p.sel && pwrite == p.write &&
                        write_paddr == (p.write ? p.addr : 5'd0) &&
                        apb_read_paddr == (p.write ? 5'd0 : p.addr);
              chk("access_hold", {31'd0, hold_ok}, 32'd1);
              pready = (k == p.waits);
              k++;
              n_acc++;
            end
          end
          pready = 1'b0;
          exp_len = (p.waits >= TMO) ? TMO : p.waits + 1;
          if (!rst_abort) chk("access_len", n_acc, exp_len);
        end
      end
    end
  end

  // Response monitor: picks rsp_ready, and checks the response accepted at the next edge.
  initial begin
    rsp_t e;
    forever begin
      @(posedge pclk); #1;
      if (!Reset) begin
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_code", rsp_code, e.code);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    bit any;
    bit w;
    logic [1:0] s;
    int r, wt;

    repeat (3) @(posedge pclk);
    #1;
    chk("rst_transfer", transfer, 0);
    chk("rst_penable", penable, 0);
    chk("rst_psel", Psel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge pclk) Reset = 1'b1;

    // GPIO write, zero wait states, and accept-to-response latency
    send(mk(1'b1, 2'd1, 5'h02, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b0, 3'b000));
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge pclk); #1;
      cyc++;
      if (rsp_valid) break;
    end
    chk("wr_latency", cyc, 3);
    drain();

    // UART read with 3 wait states
    send(mk(1'b0, 2'd2, 5'h04, 32'h0, 3, 32'h0000_0041, 1'b0, 3'b000));
    drain();

    // Timeout then a normal command behind it
    send(mk(1'b0, 2'd1, 5'h07, 32'h0, 40, 32'hDEAD_BEEF, 1'b1, 3'b011));
    send(mk(1'b1, 2'd2, 5'h09, 32'h1234_5678, 1, 32'h0, 1'b0, 3'b000));
    drain();

    // Slave error, then illegal selects
    send(mk(1'b0, 2'd2, 5'h03, 32'h0, 2, 32'hCAFE_0000, 1'b1, 3'b010));
    send(mk(1'b1, 2'd0, 5'h01, 32'h77, 0, 32'h0, 1'b0, 3'b000));
    send(mk(1'b0, 2'd3, 5'h1F, 32'h0, 0, 32'h0, 1'b0, 3'b000));
    drain();

    // Fill FIFO behind a stalled response; order checked on release
    hold_rsp = 1'b1;
    for (int i = 0; i < 5; i++)
      send(mk(1'b0, 2'd2, 5'(i), 32'h0, 0, 32'h100 + i, 1'b0, 3'(i)));
    repeat (3) @(posedge pclk);
    #1;
    chk("fifo_full_ready", cmd_ready, 0);
    chk("fifo_full_rsp_valid", rsp_valid, 1);
    hold_rsp = 1'b0;
    drain();

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      s = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      w = $urandom_range(0, 1);
      wt = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      send(mk(w, s, 5'($urandom), $urandom, wt, $urandom, 1'($urandom_range(0, 3) == 0),
              3'($urandom)));
    end
    drain();

    // Reset during an ACCESS wait with commands still queued
    send(mk(1'b0, 2'd2, 5'h05, 32'h0, 12, 32'h55, 1'b0, 3'b000));
    send(mk(1'b1, 2'd1, 5'h06, 32'h66, 0, 32'h0, 1'b0, 3'b000));
    send(mk(1'b0, 2'd1, 5'h07, 32'h0, 0, 32'h77, 1'b0, 3'b000));
    any = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge pclk); #1;
      if (penable) begin any = 1'b1; break; end
    end
    chk("reach_access", any, 1);
    repeat (2) @(posedge pclk);
    #3;
    rst_abort = 1'b1;
    Reset = 1'b0;
    #1;
    chk("midrst_transfer", transfer, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    plan_q.delete();
    @(negedge pclk) Reset = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    any = 1'b0;
    repeat (20) begin
      @(posedge pclk); #1;
      if (transfer || rsp_valid) any = 1'b1;
    end
    chk("fifo_flushed", any, 0);
    rst_abort = 1'b0;

    send(mk(1'b0, 2'd1, 5'h0A, 32'h0, 1, 32'hBEEF_0001, 1'b0, 3'b001));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_cmd_sequencer.md
Name: apb_cmd_sequencer

Overview:
- Upstream command stage feeding APB_Protcol.
- Accepts queued read/write commands from a host-side valid/ready interface and buffers them in a small command FIFO.
- Drives the bridge's transfer/penable/pwrite/Psel/address/data inputs through the APB SETUP/ACCESS phases.
- Returns read data and error status on a response valid/ready interface, with a per-access timeout.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TIMEOUT, 16, max ACCESS cycles waiting for pready before forced abort (≥1)

Ports:
- pclk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1=write, 0=read
- cmd_sel  in  2  1=GPIO, 2=UART; 0/3 illegal
- cmd_addr  in  5  register address
- cmd_wdata  in  32  write data
- transfer  out  1  to bridge
- penable  out  1  to bridge
- pwrite  out  1  to bridge
- Psel  out  2  to bridge
- write_paddr  out  5  to bridge, valid on writes
- apb_read_paddr  out  5  to bridge, valid on reads
- write_data  out  32  to bridge
- pready  in  1  selected-slave ready (bridge mux output)
- apb_read_data_out  in  32  read data from bridge
- PSLVERR  in  1  bridge error flag
- Error_Identify  in  3  bridge error code
- rsp_valid  out  1  response available
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  32  captured read data (0 for writes)
- rsp_err  out  1  PSLVERR, timeout or illegal sel
- rsp_code  out  3  Error_Identify captured; 3'b111 = timeout; 3'b110 = illegal sel

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; FIFO empty; all outputs 0; cmd_ready=1; timeout counter=0.
- FIFO push when cmd_valid&&cmd_ready; pop on IDLE→SETUP. Pointers wrap modulo CMD_DEPTH; full/empty via an extra pointer bit. Simultaneous push and pop on a full FIFO: the push is refused, because cmd_ready reflects registered full.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Head entry with cmd_sel ∈ {1,2}: pop, latch it, go to SETUP next cycle.
  - cmd_sel ∈ {0,3}: pop, skip the bus, go to RESP with rsp_err=1, rsp_code=110.
- SETUP (exactly 1 cycle): transfer=1, penable=0, Psel/pwrite/address/write_data driven from the latched entry. The unused address port = 0. Next state: ACCESS.
- ACCESS:
  - transfer=1, penable=1, signals held stable. Timeout counter increments each cycle.
  - pready=1: capture apb_read_data_out (reads only), PSLVERR→rsp_err, Error_Identify→rsp_code. Go to RESP.
  - Counter reaches TIMEOUT with pready still 0: rsp_err=1, rsp_code=111, rsp_rdata=0. Go to RESP.
  - Minimum SETUP-to-response latency: 2 cycles. Command accept to rsp_valid: ≥3 cycles.
- RESP:
  - transfer=0, penable=0, Psel=0, rsp_valid=1. Response fields held stable until rsp_ready=1.
  - Handshake cycle: rsp_valid drops and the FSM goes to IDLE. Next SETUP is ≥1 cycle later (no back-to-back ACCESS).
- Bus outputs are registered; no combinational path from cmd_* or rsp_ready to bus outputs.
- Write response: rsp_rdata=0.
- Reset mid-transaction: immediate return to IDLE; FIFO contents discarded; transfer/penable drop asynchronously.
- One outstanding bus transaction at a time; commands complete strictly in FIFO order.

Test Plan:
- GPIO write: cmd(write=1, sel=1, addr=5'h02, wdata=32'hA5A5_0001), pready tied 1 → SETUP 1 cycle (transfer=1, penable=0), ACCESS 1 cycle, rsp_valid with rsp_err=0, rsp_rdata=0.
- UART read: cmd(write=0, sel=2, addr=5'h04), slave pready after 3 wait cycles, apb_read_data_out=32'h0000_0041 → apb_read_paddr=4 held stable through all waits; rsp_rdata=32'h41.
- Timeout: TIMEOUT=16, pready held 0 → ACCESS lasts 16 cycles; rsp_err=1, rsp_code=111; next queued command still executes.
- FIFO full/order: push 5 commands with rsp_ready=0 and CMD_DEPTH=4 → cmd_ready=0 after the 4th accepted entry plus the in-flight one; responses emerge in push order once rsp_ready=1.
- Error/illegal sel: slave returns PSLVERR=1, Error_Identify=3'b010 → rsp_err=1, rsp_code=010. Command sel=0 → no transfer pulse; rsp_code=110.
- Reset mid-ACCESS: deassert Reset during a wait state → transfer/penable/rsp_valid=0 immediately, cmd_ready=1 after release, FIFO empty.
